instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Instruction fetch and PC sequencer for the MIPS core.
- Produces the 32-bit instruction whose `[31:26]` field drives the main controller's `op_code`.
- Consumes the controller's `branch`/`j` outputs plus the ALU zero flag to choose the next PC.
- Owns the PC register, the instruction-memory request/ack handshake, and the hold/valid handshake toward decode.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `TIMEOUT`, default 16: max cycles in FETCH waiting for `imem_ack` before retry; range 2..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: instruction read request, held until ack.
- `imem_addr` out 32: word-aligned fetch address, equal to `pc`.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: held instruction toward decode and controller.
- `instr_valid` out 1: `instr` is valid and held.
- `dec_ready` in 1: decode/execute consumes `instr` this cycle.
- `branch` in 1: controller branch signal for the held instruction.
- `j` in 1: controller jump signal (j and jal).
- `alu_zero` in 1: ALU zero flag for the held instruction, same cycle.
- `pc` out 32: address of the held or in-flight instruction.
- `link_addr` out 32: `pc + 4`, for the jal write-back.
- `fetch_err` out 1: one-cycle pulse on ack timeout.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE:
  - `imem_req`=0.
  - Always moves to FETCH next cycle.
  - Entered from reset and after a timeout.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, wait counter increments each cycle.
  - On `imem_ack`: latch `instr`<=`imem_rdata`, set `instr_valid`, clear counter, go to HOLD.
  - If counter==TIMEOUT-1 and no ack: pulse `fetch_err`, clear counter, go to IDLE. `pc` is unchanged, so the same address is retried.
- HOLD:
  - `instr_valid`=1 and `instr` is stable.
  - `branch`/`j`/`alu_zero` are sampled only when `dec_ready`=1.
  - On `dec_ready`: update `pc` to the next PC, clear `instr_valid`, go to FETCH.
  - Without `dec_ready`: hold indefinitely.
  - `imem_ack` is ignored in HOLD and IDLE.
- Next-PC selection, priority order:
  - `j`=1: `{pc4[31:28], instr[25:0], 2'b00}`.
  - else `branch`=1 and `alu_zero`=1: `pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - else: `pc4`.
  - Here `pc4 = pc + 4`.
- Arithmetic:
  - All additions are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0.
  - Branch offset is sign-extended; negative offsets go backward.
- `link_addr` is combinational `pc + 4` and valid whenever `instr_valid`=1.
- `branch`=1 with `alu_zero`=0 gives sequential `pc4`.
- `branch`=1 with `j`=1 simultaneously: j wins.
- `branch`/`j` equal to X while `dec_ready`=0 must not affect state.

## Timing
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `fetch_err`=0, counter=0.
- Reset is asynchronous: asserting `rst` in any state, including mid-FETCH or HOLD, forces reset values immediately. An in-flight request is abandoned, and a late ack after reset is ignored unless in FETCH.
- First `imem_req` is asserted in the 2nd cycle after `rst` deasserts (IDLE takes one cycle).
- Ack-to-valid: `instr_valid` rises the cycle after the `imem_ack` edge.
- Zero-wait memory, where ack comes in the first FETCH cycle:
  - Throughput is one instruction per 2 cycles when `dec_ready` is constantly 1.
- `pc`, `imem_addr`, `instr`, and `instr_valid` are registered.
- `link_addr`, and `imem_req` (decoded from state), are combinational from registers.
- `fetch_err` is a registered single-cycle pulse.
- Retry spacing: after a timeout, `imem_req` is low for exactly 1 cycle, then the same address is reissued.
- Ack in the exact cycle the counter reaches TIMEOUT-1: the ack wins. No `fetch_err`, go to HOLD.

## Test plan
- Reset with RESET_PC=0x0040_0000, memory acks on the first request cycle, `dec_ready`=1, no branch/j:
  - `imem_addr` sequence is 0x400000, 0x400004, 0x400008.
  - `instr_valid` pulses every 2nd cycle.
- Held instruction 0x0800_0010 (j) at pc=0x0040_0000 with `j`=1 on accept:
  - next `imem_addr`=0x0000_0040.
  - jal (0x0C00_0010) gives the same target, with `link_addr`=0x0040_0004 while held.
- beq 0x1000_FFFF at pc=0x100 with `branch`=1:
  - `alu_zero`=1 gives next PC 0x100.
  - `alu_zero`=0 gives 0x104.
  - offset 0x0003 with zero=1 gives 0x110.
- Stall: hold `dec_ready`=0 for 5 cycles with toggling `branch`/`j`/`imem_ack`:
  - `instr` and `pc` are unchanged, `instr_valid` stays 1.
  - Then `dec_ready`=1 with `j`=0, `branch`=0 gives pc+4.
- Timeout with TIMEOUT=4 and no ack:
  - `fetch_err` pulses on the 4th FETCH cycle, `imem_req` drops 1 cycle, same address is reissued.
  - Ack exactly on the 4th cycle: no `fetch_err`, instruction is accepted.
- Assert `rst` mid-FETCH at pc=0x200, then ack after deassert while in IDLE:
  - outputs return to reset values immediately, the late ack is ignored, and fetch restarts at RESET_PC.
- Wrap: pc=0xFFFF_FFFC, sequential accept gives next `imem_addr`=0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory handshake, decode hold/valid handshake,
// and the controller's next-PC inputs.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        dec_ready;
    logic        branch;
    logic        j;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        fetch_err;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, link_addr, fetch_err,
        input  imem_ack, imem_rdata, dec_ready, branch, j, alu_zero
    );

    // Memory / decode / controller side
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, link_addr, fetch_err,
        output imem_ack, imem_rdata, dec_ready, branch, j, alu_zero
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and PC sequencer: fetches the word at pc, holds it for
// decode, then steps pc by sequential / branch / jump rules on accept.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] npc;

    // Next-PC select for the held instruction; jump beats a taken branch
    always_comb begin
        pc4    = pc_q + 32'd4;
        br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (bus.j)
            npc = {pc4[31:28], instr_q[25:0], 2'b00};
        else if (bus.branch && bus.alu_zero)
            npc = pc4 + br_off;
        else
            npc = pc4;
    end

    // Sequencer: IDLE -> FETCH (wait for ack or time out) -> HOLD (wait for decode)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // An ack in the final wait cycle still wins over the timeout
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = HOLD;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                // Controller inputs only matter on the accept cycle
                if (bus.dec_ready) begin
                    pc_d    = npc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.link_addr   = pc_q + 32'd4;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_instr_fetch_unit;
    localparam int          TMO = 4;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if wbus ();

    instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .bus(wbus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_instr = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_req   = 1'b0;
    logic        m_err   = 1'b0;
    int          m_wait  = 0;

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                              input logic br, input logic jj, input logic z);
        logic [31:0] p4;
        logic [31:0] offb;
        int          off;
        p4 = p + 32'd4;
        if (jj) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && z) begin
            off  = int'(signed'(ins[15:0]));
            offb = off * 4;
            return p4 + offb;
        end
        return p4;
    endfunction

    // Check every cycle at the falling edge, then advance the model by the
    // inputs the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            m_pc = RPC; m_instr = 32'd0; m_valid = 1'b0;
            m_req = 1'b0; m_err = 1'b0; m_wait = 0;
        end
        chk("m_req",   32'(bus.imem_req),    32'(m_req));
        chk("m_addr",  bus.imem_addr,        m_pc);
        chk("m_pc",    bus.pc,               m_pc);
        chk("m_link",  bus.link_addr,        m_pc + 32'd4);
        chk("m_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("m_instr", bus.instr,            m_instr);
        chk("m_err",   32'(bus.fetch_err),   32'(m_err));
        if (!rst) begin
            m_err = 1'b0;
            if (m_valid) begin
                if (bus.dec_ready) begin
                    m_pc    = model_npc(m_pc, m_instr, bus.branch, bus.j, bus.alu_zero);
                    m_valid = 1'b0;
                    m_req   = 1'b1;
                    m_wait  = 0;
                end
            end else if (m_req) begin
                if (bus.imem_ack) begin
                    m_instr = bus.imem_rdata;
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                    m_wait  = 0;
                end else if (m_wait == TMO - 1) begin
                    m_err  = 1'b1;
                    m_req  = 1'b0;
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_req = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic ack, input logic [31:0] rd, input logic dr,
                         input logic br, input logic jj, input logic z);
        @(posedge clk);
        #1;
        bus.imem_ack = ack; bus.imem_rdata = rd; bus.dec_ready = dr;
        bus.branch = br; bus.j = jj; bus.alu_zero = z;
    endtask

    // One zero-wait fetch at addr followed by an accept with the given controls
    task automatic xfer(input logic [31:0] addr, input logic [31:0] word,
                        input logic br, input logic jj, input logic z);
        drive(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("fetch_req",  32'(bus.imem_req), 32'd1);
        chk("fetch_addr", bus.imem_addr, addr);
        drive(1'b0, 32'd0, 1'b1, br, jj, z);
        #3;
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_instr", bus.instr, word);
        chk("hold_link",  bus.link_addr, addr + 32'd4);
    endtask

    // Wrap instance: always acks and accepts; second fetch address must wrap to 0
    initial begin
        wbus.imem_ack = 1'b1; wbus.imem_rdata = 32'd0; wbus.dec_ready = 1'b1;
        wbus.branch = 1'b0; wbus.j = 1'b0; wbus.alu_zero = 1'b0;
        @(negedge rst);
        #3;
        chk("wrap_idle_req", 32'(wbus.imem_req), 32'd0);
        @(posedge clk); #4;
        chk("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #4;
        chk("wrap_valid", 32'(wbus.instr_valid), 32'd1);
        @(posedge clk); #4;
        chk("wrap_req",   32'(wbus.imem_req), 32'd1);
        chk("wrap_addr1", wbus.imem_addr, 32'h0000_0000);
    end

    initial begin
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.dec_ready = 1'b0;
        bus.branch = 1'b0; bus.j = 1'b0; bus.alu_zero = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_pc",    bus.pc, RPC);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;                                    // IDLE cycle follows
        #3;
        chk("idle_req", 32'(bus.imem_req), 32'd0);

        // Sequential stream, jumps, jal link, branches
        xfer(32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        xfer(32'h0040_0004, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        xfer(32'h0040_0008, 32'h0800_0010, 1'b0, 1'b1, 1'b0);
        xfer(32'h0000_0040, 32'h0C00_0010, 1'b0, 1'b1, 1'b0);
        xfer(32'h0000_0040, 32'h0800_0040, 1'b0, 1'b1, 1'b0);
        xfer(32'h0000_0100, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        xfer(32'h0000_0100, 32'h1000_0003, 1'b1, 1'b0, 1'b1);
        xfer(32'h0000_0110, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
        xfer(32'h0000_0114, 32'h0800_0040, 1'b1, 1'b1, 1'b1);

        // Stall with noisy controls and stray acks
        drive(1'b1, 32'h2222_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("stall_addr", bus.imem_addr, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            drive(1'(i % 2), $urandom, 1'b0, 1'((i + 1) % 2), 1'(i % 2), 1'b1);
            #3;
            chk("stall_instr", bus.instr, 32'h2222_0000);
            chk("stall_pc",    bus.pc, 32'h0000_0100);
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Timeout at 0x104, retry, then ack on the last allowed cycle
        repeat (4) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("tmo_err", 32'(bus.fetch_err), 32'd1);
        chk("tmo_req", 32'(bus.imem_req), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("retry_req",  32'(bus.imem_req), 32'd1);
        chk("retry_addr", bus.imem_addr, 32'h0000_0104);
        chk("retry_err",  32'(bus.fetch_err), 32'd0);
        repeat (2) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        chk("lastack_valid", 32'(bus.instr_valid), 32'd1);
        chk("lastack_err",   32'(bus.fetch_err), 32'd0);
        chk("lastack_instr", bus.instr, 32'h0000_5555);

        // Reset mid-FETCH at 0x200, late ack in IDLE is ignored
        xfer(32'h0000_0108, 32'h0800_0080, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("mid_addr", bus.imem_addr, 32'h0000_0200);
        rst = 1'b1;
        #1;
        chk("arst_pc",    bus.pc, RPC);
        chk("arst_req",   32'(bus.imem_req), 32'd0);
        chk("arst_instr", bus.instr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        #3;
        chk("late_req", 32'(bus.imem_req), 32'd0);
        xfer(32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 249) == 0);
            bus.imem_ack  = ($urandom_range(0, 99) < 35);
            bus.imem_rdata = $urandom;
            bus.dec_ready = ($urandom_range(0, 1) == 1);
            bus.branch    = ($urandom_range(0, 1) == 1);
            bus.j         = ($urandom_range(0, 4) == 0);
            bus.alu_zero  = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
